// File: rtl/img_cfg_pkg.sv
// Shared types and constants for the image-pipeline configuration controller.
package img_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } rx_state_e;

    localparam logic [7:0] HDR       = 8'hA5;

    localparam logic [2:0] ADDR_D1UP = 3'd0;
    localparam logic [2:0] ADDR_D1DN = 3'd1;
    localparam logic [2:0] ADDR_D2UP = 3'd2;
    localparam logic [2:0] ADDR_D2DN = 3'd3;
    localparam logic [2:0] ADDR_MODE = 3'd4;

    localparam logic [7:0] DEF_D1_UP = 8'd255;
    localparam logic [7:0] DEF_D1_DN = 8'd0;
    localparam logic [7:0] DEF_D2_UP = 8'd255;
    localparam logic [7:0] DEF_D2_DN = 8'd0;

    // Frame check byte is the XOR of address and data.
    function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
        return addr ^ data;
    endfunction

endpackage

// File: rtl/img_cfg_rx_parser.sv
// Byte-level parser for 4-byte UART command frames (HDR, ADDR, DATA, CHK) with inter-byte timeout.
module img_cfg_rx_parser
    import img_cfg_pkg::*;
#(
    parameter int NUM_MODES   = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    rx_state_e        state_r;
    rx_state_e        state_nxt_s;
    logic [7:0]       addr_r;
    logic [7:0]       data_r;
    logic [CNT_W-1:0] cnt_r;
    logic             chk_ok_s;
    logic             addr_ok_s;
    logic             wr_en_s;
    logic             err_s;

    assign chk_ok_s  = (rx_data == frame_chk(addr_r, data_r));
    // Address above the mode slot, or a mode value out of range, is rejected.
    assign addr_ok_s = (addr_r <= 8'(ADDR_MODE)) &&
                       !((addr_r == 8'(ADDR_MODE)) && (data_r >= 8'(NUM_MODES)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, write strobe and error decode; a received byte takes priority over timeout.
    always_comb begin
        state_nxt_s = state_r;
        wr_en_s     = 1'b0;
        err_s       = 1'b0;
        if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_data == HDR) begin
                        state_nxt_s = ST_ADDR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_ADDR: state_nxt_s = ST_DATA;
                ST_DATA: state_nxt_s = ST_CHK;
                ST_CHK: begin
                    state_nxt_s = ST_IDLE;
                    if (chk_ok_s && addr_ok_s) begin
                        wr_en_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else if ((state_r != ST_IDLE) && (cnt_r == CNT_LAST)) begin
            state_nxt_s = ST_IDLE;
            err_s       = 1'b1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Capture address and data bytes of the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= 8'd0;
            data_r <= 8'd0;
        end else begin
            if (rx_valid && (state_r == ST_ADDR)) begin
                addr_r <= rx_data;
            end
            if (rx_valid && (state_r == ST_DATA)) begin
                data_r <= rx_data;
            end
        end
    end

    // Inter-byte timeout counter, idle outside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (rx_valid || (state_r == ST_IDLE)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign wr_en   = wr_en_s;
    assign wr_addr = addr_r[2:0];
    assign wr_data = data_r;
    assign err     = err_s;

endmodule

// File: rtl/img_cfg_ctrl.sv
// Run-time configuration controller: shadow registers fed by keys/UART, committed to outputs on vsync rise.
module img_cfg_ctrl
    import img_cfg_pkg::*;
#(
    parameter int         NUM_MODES   = 4,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter logic [7:0] D1_UP_RST   = DEF_D1_UP,
    parameter logic [7:0] D1_DN_RST   = DEF_D1_DN,
    parameter logic [7:0] D2_UP_RST   = DEF_D2_UP,
    parameter logic [7:0] D2_DN_RST   = DEF_D2_DN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_next,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       vsync_i,
    output logic [1:0] mode_o,
    output logic [7:0] data1_up,
    output logic [7:0] data1_down,
    output logic [7:0] data2_up,
    output logic [7:0] data2_down,
    output logic       cmd_ack,
    output logic       cfg_err,
    output logic       cfg_commit
);

    logic       wr_en_s;
    logic [2:0] wr_addr_s;
    logic [7:0] wr_data_s;
    logic       err_s;
    logic       commit_s;
    logic       mode_wr_s;
    logic [1:0] mode_inc_s;

    logic       vsync_d_r;
    logic [1:0] sh_mode_r;
    logic [7:0] sh_d1_up_r, sh_d1_dn_r, sh_d2_up_r, sh_d2_dn_r;
    logic [1:0] mode_r;
    logic [7:0] d1_up_r, d1_dn_r, d2_up_r, d2_dn_r;
    logic       cmd_ack_r, cfg_err_r, cfg_commit_r;

    img_cfg_rx_parser #(
        .NUM_MODES   (NUM_MODES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_parser (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_en    (wr_en_s),
        .wr_addr  (wr_addr_s),
        .wr_data  (wr_data_s),
        .err      (err_s)
    );

    assign commit_s   = vsync_i & ~vsync_d_r;
    assign mode_wr_s  = wr_en_s && (wr_addr_s == ADDR_MODE);
    assign mode_inc_s = (sh_mode_r == 2'(NUM_MODES - 1)) ? 2'd0 : (sh_mode_r + 2'd1);

    // Shadow display mode; a UART mode write overrides a simultaneous key press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mode_r <= 2'd0;
        end else if (mode_wr_s) begin
            sh_mode_r <= wr_data_s[1:0];
        end else if (key_next) begin
            sh_mode_r <= mode_inc_s;
        end
    end

    // Shadow thresholds written by accepted UART frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_d1_up_r <= D1_UP_RST;
            sh_d1_dn_r <= D1_DN_RST;
            sh_d2_up_r <= D2_UP_RST;
            sh_d2_dn_r <= D2_DN_RST;
        end else if (wr_en_s) begin
            case (wr_addr_s)
                ADDR_D1UP: sh_d1_up_r <= wr_data_s;
                ADDR_D1DN: sh_d1_dn_r <= wr_data_s;
                ADDR_D2UP: sh_d2_up_r <= wr_data_s;
                ADDR_D2DN: sh_d2_dn_r <= wr_data_s;
                default:   sh_d1_up_r <= sh_d1_up_r;
            endcase
        end
    end

    // Active outputs load the pre-write shadows on vsync rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= 2'd0;
            d1_up_r <= D1_UP_RST;
            d1_dn_r <= D1_DN_RST;
            d2_up_r <= D2_UP_RST;
            d2_dn_r <= D2_DN_RST;
        end else if (commit_s) begin
            mode_r  <= sh_mode_r;
            d1_up_r <= sh_d1_up_r;
            d1_dn_r <= sh_d1_dn_r;
            d2_up_r <= sh_d2_up_r;
            d2_dn_r <= sh_d2_dn_r;
        end
    end

    // Status pulses and vsync edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r    <= 1'b0;
            cmd_ack_r    <= 1'b0;
            cfg_err_r    <= 1'b0;
            cfg_commit_r <= 1'b0;
        end else begin
            vsync_d_r    <= vsync_i;
            cmd_ack_r    <= wr_en_s;
            cfg_err_r    <= err_s;
            cfg_commit_r <= commit_s;
        end
    end

    assign mode_o     = mode_r;
    assign data1_up   = d1_up_r;
    assign data1_down = d1_dn_r;
    assign data2_up   = d2_up_r;
    assign data2_down = d2_dn_r;
    assign cmd_ack    = cmd_ack_r;
    assign cfg_err    = cfg_err_r;
    assign cfg_commit = cfg_commit_r;

endmodule
